// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO. It has run-time parity, compile-time format and baud.
// Define UART_TX_BREAK_EN to add the i_break input and the line-break states.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_tx_dr,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic [1:0]           i_parity_mode,
`ifdef UART_TX_BREAK_EN
  input  logic                 i_break,
`endif
  output logic                 o_serial,
  output logic                 o_tx_busy,
  output logic                 o_tx_done,
  output logic                 o_fifo_full,
  output logic                 o_fifo_empty,
  output logic                 o_overflow
);

  // state  | meaning
  // IDLE   | line high, waiting for a queued byte
  // START  | start bit (low), one bit time
  // DATA   | DATA_BITS payload bits, LSB first
  // PARITY | parity bit, only when latched mode != 00
  // STOP   | STOP_BITS stop bits (high); pops the next byte at the end
  // BREAK  | line held low while i_break is high
  // MAB    | mark-after-break, one bit time high

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK,
    S_MAB
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  acc_q, acc_d;
  logic [1:0]            mode_q, mode_d;
  logic                  serial_q, serial_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  tx_dr_q;
  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, empty_q, ovf_q;

  logic                  push, wr_en, pop, bit_end;
  logic [TW-1:0]         timer_inc;

  function automatic logic parity_bit(input logic [1:0] mode, input logic acc);
    case (mode)
      2'b01:   return ~acc;
      2'b10:   return acc;
      default: return 1'b1;
    endcase
  endfunction

  // ---------------- FIFO ----------------
  assign push    = i_tx_dr & ~tx_dr_q;
  // The full flag is checked before any same-cycle pop, so a push on a full FIFO is always lost.
  assign wr_en   = push & ~full_q;
  assign count_d = count_q + CW'(wr_en) - CW'(pop);

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_dr_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      tx_dr_q  <= i_tx_dr;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      full_q   <= (count_d == CW'(FIFO_DEPTH));
      empty_q  <= (count_d == '0);
      if (push && full_q) ovf_q <= 1'b1;
    end
  end

  // ---------------- transmit FSM ----------------
  assign bit_end   = (timer_q == TW'(CLKS_PER_BIT - 1));
  assign timer_inc = bit_end ? '0 : timer_q + TW'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    pop     = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        idx_d   = '0;
`ifdef UART_TX_BREAK_EN
        if (i_break)       state_d = S_BREAK;
        else if (!empty_q) pop = 1'b1;
`else
        if (!empty_q) pop = 1'b1;
`endif
      end
      S_START: begin
        timer_d = timer_inc;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        timer_d = timer_inc;
        if (bit_end) begin
          shift_d = shift_q >> 1;
          acc_d   = acc_q ^ shift_q[0];
          if (idx_q == IW'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (mode_q != 2'b00) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PARITY: begin
        timer_d = timer_inc;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        timer_d = timer_inc;
        if (bit_end) begin
          if (idx_q == IW'(STOP_BITS - 1)) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (!empty_q) pop = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        timer_d = '0;
        if (!i_break) state_d = S_MAB;
      end
      S_MAB: begin
        timer_d = timer_inc;
        if (bit_end) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // A pop from IDLE or from the last stop bit loads the next frame identically.
    if (pop) begin
      shift_d = mem[rd_ptr_q];
      mode_d  = i_parity_mode;
      acc_d   = 1'b0;
      idx_d   = '0;
      timer_d = '0;
      state_d = S_START;
    end
  end

  // The line level is registered from the next-state values so o_serial never glitches.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[0];
      S_PARITY: serial_d = parity_bit(mode_d, acc_d);
`ifdef UART_TX_BREAK_EN
      S_BREAK:  serial_d = 1'b0;
`endif
      default:  serial_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      acc_q    <= 1'b0;
      mode_q   <= 2'b00;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_serial     = serial_q;
  assign o_tx_busy    = busy_q;
  assign o_tx_done    = done_q;
  assign o_fifo_full  = full_q;
  assign o_fifo_empty = empty_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a line-level receiver monitor checks each frame against a scoreboard.
// Stimulus is randomised with $urandom, and a timing model decides which pushes are accepted.
module tb_uart_tx_fifo;
  localparam int CPB = 4, DB = 8, SB = 1, DEPTH = 4;

  logic       i_clk = 1'b0, i_reset_n = 1'b0, i_tx_dr = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic [1:0] i_parity_mode = 2'b00;
  logic       o_serial, o_tx_busy, o_tx_done, o_fifo_full, o_fifo_empty, o_overflow;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_tx_dr(i_tx_dr), .i_data(i_data),
    .i_parity_mode(i_parity_mode),
`ifdef UART_TX_BREAK_EN
    .i_break(1'b0),
`endif
    .o_serial(o_serial), .o_tx_busy(o_tx_busy), .o_tx_done(o_tx_done),
    .o_fifo_full(o_fifo_full), .o_fifo_empty(o_fifo_empty), .o_overflow(o_overflow));

  always #5 i_clk = ~i_clk;

  typedef struct {logic [7:0] data; logic [1:0] mode;} frame_t;
  frame_t exp_q[$];

  int n_pass = 0, n_total = 0, cyc = 0;
  int busy_cnt = 0, done_cnt = 0, run = 0, last_run = 0;
  int acc_n = 0, first_pop = 0, frame_len = 40;
  bit m_ovf = 1'b0;

  always @(posedge i_clk) cyc++;

  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_tx_done) done_cnt++;
      if (o_tx_busy) begin
        busy_cnt++;
        run++;
      end else begin
        if (run != 0) last_run = run;
        run = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int flen(input logic [1:0] m);
    return (1 + DB + ((m != 2'b00) ? 1 : 0) + SB) * CPB;
  endfunction

  function automatic int exp_parity(input logic [7:0] d, input logic [1:0] m);
    int ones = $countones(d);
    case (m)
      2'b01:   return (ones % 2 == 0) ? 1 : 0;
      2'b10:   return ones % 2;
      default: return 1;
    endcase
  endfunction

  // Frames of a burst leave the FIFO at first_pop, first_pop+L, first_pop+2L, and so on.
  function automatic int pops_le(input int t);
    int p;
    if (acc_n == 0 || t < first_pop) return 0;
    p = (t - first_pop) / frame_len + 1;
    return (p < acc_n) ? p : acc_n;
  endfunction

  task automatic new_burst(input logic [1:0] m);
    acc_n = 0;
    frame_len = flen(m);
  endtask

  task automatic clear_counters();
    @(negedge i_clk);
    #1;
    busy_cnt = 0; done_cnt = 0; run = 0; last_run = 0;
  endtask

  task automatic push(input logic [7:0] d, input int hold);
    int e, occ;
    @(negedge i_clk);
    i_data = d;
    i_tx_dr = 1'b1;
    e = cyc + 1;
    occ = acc_n - pops_le(e - 1);
    if (occ < DEPTH) begin
      if (acc_n == 0) first_pop = e + 1;
      acc_n++;
      exp_q.push_back('{d, i_parity_mode});
    end else begin
      m_ovf = 1'b1;
    end
    @(negedge i_clk);
    chk("fifo_full", int'(o_fifo_full), ((acc_n - pops_le(e)) >= DEPTH) ? 1 : 0);
    chk("overflow", int'(o_overflow), int'(m_ovf));
    repeat (hold - 1) @(negedge i_clk);
    i_tx_dr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(o_fifo_empty && !o_tx_busy) && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    chk("idle_within_budget", (n < budget) ? 1 : 0, 1);
    repeat (4) @(negedge i_clk);
  endtask

  task automatic run_single(input logic [7:0] d, input logic [1:0] m, input int hold,
                            input bit chg, input bit lat);
    clear_counters();
    new_burst(m);
    i_parity_mode = m;
    push(d, hold);
    if (lat) begin
      chk("pre_start_idle", int'(o_serial), 1);
      @(posedge i_clk);
      #1 chk("start_latency", int'(o_serial), 0);
    end
    if (chg) begin
      repeat (6) @(negedge i_clk);
      i_parity_mode = ~m;
    end
    wait_idle(200);
    chk("busy_len", last_run, flen(m));
    chk("busy_total", busy_cnt, flen(m));
    chk("done_count", done_cnt, 1);
  endtask

  task automatic run_burst(input logic [7:0] d[], input logic [1:0] m, input int n_frames);
    clear_counters();
    new_burst(m);
    i_parity_mode = m;
    foreach (d[i]) push(d[i], 1);
    wait_idle(1000);
    chk("burst_busy_run", last_run, n_frames * flen(m));
    chk("burst_done_count", done_cnt, n_frames);
    chk("burst_empty", int'(o_fifo_empty), 1);
  endtask

  task automatic wait_n(input int n, output bit ab);
    ab = 1'b0;
    repeat (n) begin
      @(negedge i_clk);
      if (!i_reset_n) ab = 1'b1;
    end
  endtask

  // Line monitor: a receiver that samples mid-bit and compares each decoded frame with the scoreboard.
  initial begin : monitor
    frame_t f;
    bit ab, have;
    logic [7:0] got;
    logic par;
    forever begin
      @(negedge i_clk);
      if (!i_reset_n || o_serial) continue;
      have = (exp_q.size() != 0);
      if (!have) begin
        chk("unexpected_frame", exp_q.size(), 1);
        f = '{8'h00, 2'b00};
      end else begin
        f = exp_q[0];
      end
      wait_n(2, ab);
      if (ab) continue;
      chk("start_bit", int'(o_serial), 0);
      got = 8'h00;
      for (int i = 0; i < DB; i++) begin
        wait_n(CPB, ab);
        if (ab) break;
        got[i] = o_serial;
      end
      if (ab) continue;
      par = 1'b1;
      if (f.mode != 2'b00) begin
        wait_n(CPB, ab);
        if (ab) continue;
        par = o_serial;
      end
      wait_n(CPB, ab);
      if (ab) continue;
      chk("stop_bit", int'(o_serial), 1);
      if (have) begin
        void'(exp_q.pop_front());
        chk("frame_data", int'(got), int'(f.data));
        if (f.mode != 2'b00) chk("parity_bit", int'(par), exp_parity(f.data, f.mode));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] b3[];
    logic [7:0] b6[];
    logic [7:0] d;
    #12;
    chk("rst_serial", int'(o_serial), 1);
    chk("rst_busy", int'(o_tx_busy), 0);
    chk("rst_done", int'(o_tx_done), 0);
    chk("rst_full", int'(o_fifo_full), 0);
    chk("rst_empty", int'(o_fifo_empty), 1);
    chk("rst_overflow", int'(o_overflow), 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (3) @(negedge i_clk);

    // Single 8N1 frame with start-latency check
    run_single(8'h53, 2'b00, 1, 1'b0, 1'b1);
    // Parity modes: even, odd (mode changed mid-frame), mark
    run_single(8'h53, 2'b10, 1, 1'b0, 1'b0);
    run_single(8'h53, 2'b01, 1, 1'b1, 1'b0);
    run_single(8'h53, 2'b11, 1, 1'b0, 1'b0);
    // Level-held request
    run_single(8'h2D, 2'b00, 10, 1'b0, 1'b0);

    // Back-to-back: named bytes, then random bytes with a random mode
    b3 = new[3];
    b3[0] = 8'h61; b3[1] = 8'h4A; b3[2] = 8'h01;
    run_burst(b3, 2'b00, 3);
    foreach (b3[i]) b3[i] = 8'($urandom);
    run_burst(b3, 2'($urandom_range(0, 3)), 3);

    // Random single frames with a mid-frame mode change
    for (int k = 0; k < 4; k++)
      run_single(8'($urandom), 2'($urandom_range(0, 3)), 1, 1'b1, 1'b0);

    // Overflow: one frame on the line, four fill the FIFO, the sixth push is dropped
    b6 = new[6];
    foreach (b6[i]) b6[i] = 8'($urandom);
    run_burst(b6, 2'b00, 5);
    chk("overflow_sticky", int'(o_overflow), 1);

    // Asynchronous reset during data bit 3
    clear_counters();
    new_burst(2'b00);
    i_parity_mode = 2'b00;
    d = 8'h53;
    push(d, 1);
    repeat (17) @(negedge i_clk);
    chk("pre_reset_bit3", int'(o_serial), int'(d[3]));
    #1 i_reset_n = 1'b0;
    exp_q.delete();
    acc_n = 0;
    m_ovf = 1'b0;
    #1;
    chk("arst_serial", int'(o_serial), 1);
    chk("arst_busy", int'(o_tx_busy), 0);
    chk("arst_empty", int'(o_fifo_empty), 1);
    chk("arst_full", int'(o_fifo_full), 0);
    chk("arst_overflow", int'(o_overflow), 0);
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clk);
    run_single(8'h2D, 2'b00, 1, 1'b0, 1'b1);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
